// File: rtl/sample_mixer_if.sv
// rtl/sample_mixer_if.sv - sample-memory read port between the mixer and a synchronous ROM
interface sample_mixer_if #(
  parameter int AW = 17,
  parameter int DW = 8
);
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;

  modport master (output mem_rd, output mem_addr, input mem_data);
  modport slave  (input mem_rd, input mem_addr, output mem_data);
endinterface

// File: rtl/sample_mixer.sv
// rtl/sample_mixer.sv - multi-channel one-shot/looping sample player, volume mixer and PWM output
module sample_mixer #(
  parameter int NCH  = 4,
  parameter int AW   = 17,
  parameter int DW   = 8,
  parameter int DIVW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    start,
  input  logic [NCH-1:0]    stop,
  input  logic [NCH-1:0]    loop,
  input  logic [NCH*AW-1:0] ch_base,
  input  logic [NCH*AW-1:0] ch_len,
  input  logic [NCH*4-1:0]  ch_vol,
  input  logic [DIVW-1:0]   rate_div,
  sample_mixer_if.master    mem,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    done,
  output logic [DW-1:0]     pcm,
  output logic              audio
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW = DW + 4 + ((NCH > 1) ? $clog2(NCH) : 0);
  localparam logic [DIVW-1:0] MIN_LIM = DIVW'(2 * NCH + 1);
  localparam logic [SW-1:0]   PCM_MAX = SW'({DW{1'b1}});

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;
  localparam logic [1:0] S_MIX  = 2'd3;

  logic [DIVW-1:0] cnt_q, lim_q;
  logic            tick;
  logic [1:0]      state_q;
  logic [CW-1:0]   ch_q;
  logic [AW-1:0]   base_q [NCH];
  logic [AW-1:0]   len_q  [NCH];
  logic [AW-1:0]   pos_q  [NCH];
  logic [3:0]      vol_q  [NCH];
  logic [DW-1:0]   smp_q  [NCH];
  logic [NCH-1:0]  busy_q, loop_q, fetched_q, done_q;
  logic [AW-1:0]   addr_q;
  logic            rd_now;
  logic [SW-1:0]   sum_d, shr_d;
  logic [DW-1:0]   pcm_d, pcm_q, pwm_q, duty_q;

  // The period limit is captured when the counter restarts, so rate_div edits land at the next wrap.
  assign tick = (cnt_q != '0) && (cnt_q == lim_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      lim_q <= '0;
    end else begin
      if (cnt_q == '0) lim_q <= (rate_div > MIN_LIM) ? rate_div : MIN_LIM;
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (tick) begin
          state_q <= S_REQ;
          ch_q    <= '0;
        end
        S_REQ: state_q <= S_CAP;
        S_CAP: if (ch_q == CW'(NCH - 1)) begin
          state_q <= S_MIX;
        end else begin
          state_q <= S_REQ;
          ch_q    <= ch_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_now       = (state_q == S_REQ) && busy_q[ch_q];
  assign mem.mem_rd   = rd_now;
  assign mem.mem_addr = rd_now ? base_q[ch_q] + pos_q[ch_q] : addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_q <= '0;
    else        addr_q <= mem.mem_addr;
  end

  // Only channels fetched in this frame's REQ slot contribute, so late starts mix as silence.
  always_comb begin
    sum_d = '0;
    for (int c = 0; c < NCH; c++) begin
      if (busy_q[c] && fetched_q[c]) sum_d = sum_d + SW'(smp_q[c]) * SW'(vol_q[c]);
    end
    shr_d = sum_d >> 4;
    pcm_d = (shr_d > PCM_MAX) ? {DW{1'b1}} : shr_d[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= '0;
      loop_q    <= '0;
      fetched_q <= '0;
      done_q    <= '0;
      pcm_q     <= '0;
      for (int c = 0; c < NCH; c++) begin
        base_q[c] <= '0;
        len_q[c]  <= '0;
        pos_q[c]  <= '0;
        vol_q[c]  <= '0;
        smp_q[c]  <= '0;
      end
    end else begin
      done_q <= '0;
      if (state_q == S_MIX) pcm_q <= pcm_d;
      for (int c = 0; c < NCH; c++) begin
        if (state_q == S_REQ && ch_q == CW'(c)) fetched_q[c] <= busy_q[c];
        if (state_q == S_CAP && ch_q == CW'(c) && fetched_q[c]) smp_q[c] <= mem.mem_data;
        if (state_q == S_MIX) begin
          fetched_q[c] <= 1'b0;
          if (busy_q[c] && fetched_q[c]) begin
            if (pos_q[c] + AW'(1) < len_q[c]) begin
              pos_q[c] <= pos_q[c] + AW'(1);
            end else if (loop_q[c]) begin
              pos_q[c] <= '0;
            end else begin
              busy_q[c] <= 1'b0;
              done_q[c] <= 1'b1;
            end
          end
        end
        // Host requests come last so they override any frame update on the same cycle.
        if (start[c] && ch_len[c*AW +: AW] != '0) begin
          base_q[c]    <= ch_base[c*AW +: AW];
          len_q[c]     <= ch_len[c*AW +: AW];
          vol_q[c]     <= ch_vol[c*4 +: 4];
          loop_q[c]    <= loop[c];
          pos_q[c]     <= '0;
          busy_q[c]    <= 1'b1;
          fetched_q[c] <= 1'b0;
          done_q[c]    <= 1'b0;
        end else if (stop[c]) begin
          busy_q[c]    <= 1'b0;
          fetched_q[c] <= 1'b0;
          done_q[c]    <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q  <= '0;
      duty_q <= '0;
    end else begin
      pwm_q <= pwm_q + 1'b1;
      if (pwm_q == '0) duty_q <= pcm_q;
    end
  end

  assign audio = (pwm_q < duty_q);
  assign busy  = busy_q;
  assign done  = done_q;
  assign pcm   = pcm_q;
endmodule

// File: doc/sample_mixer.md
SAMPLE_MIXER -- requirements
Module: sample_mixer

Interface
REQ-001 SHALL have parameter NCH, default 4, number of playback channels (1..8).
REQ-002 SHALL have parameter AW, default 17, sample-memory address width.
REQ-003 SHALL have parameter DW, default 8, sample and PWM resolution.
REQ-004 SHALL have parameter DIVW, default 16, sample-rate divider width.
REQ-005 SHALL have port clk  in  1  system clock (100 MHz), single clock domain, all logic on rising edge.
REQ-006 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port start  in  NCH  per-channel one-cycle play request.
REQ-008 SHALL have port stop  in  NCH  per-channel one-cycle abort request.
REQ-009 SHALL have port loop  in  NCH  per-channel repeat mode, sampled at start.
REQ-010 SHALL have port ch_base  in  NCH*AW  per-channel clip start address, packed, channel 0 at LSBs, sampled at start.
REQ-011 SHALL have port ch_len  in  NCH*AW  per-channel clip length in samples, packed, sampled at start.
REQ-012 SHALL have port ch_vol  in  NCH*4  per-channel volume 0..15 (15 = unity), packed, sampled at start.
REQ-013 SHALL have port rate_div  in  DIVW  sample period in clk cycles minus 1.
REQ-014 SHALL have port mem_rd  out  1  sample-memory read strobe.
REQ-015 SHALL have port mem_addr  out  AW  sample-memory read address.
REQ-016 SHALL have port mem_data  in  DW  read data, valid exactly one cycle after mem_rd (synchronous ROM).
REQ-017 SHALL have ports busy  out  NCH  (channel playing), done  out  NCH  (one-cycle pulse at natural clip end), pcm  out  DW  (current mixed sample), audio  out  1  (PWM output).

Function
REQ-018 Tick counter SHALL count 0..P-1 and wrap, asserting tick once per wrap, where P = max(rate_div+1, 2*NCH+2).
REQ-019 Fetch FSM states SHALL be IDLE, REQ(c), CAP(c), MIX.
REQ-020 Fetch FSM transitions SHALL be: IDLE->REQ(0) on tick; REQ(c)->CAP(c); CAP(c)->REQ(c+1), or ->MIX after c=NCH-1; MIX->IDLE.
REQ-021 In REQ(c), mem_rd SHALL be 1 and mem_addr = base[c]+pos[c] (mod 2^AW), only if busy[c]; otherwise mem_rd=0 and mem_addr holds its value.
REQ-022 In CAP(c), smp[c] SHALL be loaded from mem_data if a read was issued in REQ(c).
REQ-023 In MIX, pcm SHALL be min(2^DW-1, (sum over busy c of smp[c]*vol[c]) >> 4); the sum is full width (DW+4+clog2(NCH) bits); non-busy channels contribute 0.
REQ-024 In MIX, each busy channel SHALL advance: if pos+1 < len, pos <= pos+1; else if loop, pos <= 0; else busy <= 0 and done pulses for 1 cycle.
REQ-025 start[c] SHALL take effect on any cycle regardless of FSM state: latch base, len, vol, loop; pos <= 0; busy <= 1. A start while busy SHALL restart the channel.
REQ-026 start[c] with ch_len[c]=0 SHALL be ignored; done SHALL NOT pulse.
REQ-027 stop[c] SHALL clear busy[c] next cycle with no done pulse; it affects pcm from the next MIX.
REQ-028 Simultaneous start[c] and stop[c]: start SHALL win.
REQ-029 start or stop on the same cycle as a MIX update of that channel SHALL override the MIX update.
REQ-030 A channel started after its REQ slot in the current frame SHALL contribute 0 in that frame's MIX and SHALL NOT advance pos.
REQ-031 PWM: a free-running DW-bit counter SHALL latch duty <= pcm when the counter is 0, with audio = (counter < duty).
REQ-032 PWM SHALL produce audio constant 0 when duty=0, and high 2^DW-1 of every 2^DW cycles when duty = 2^DW-1.
REQ-033 rate_div changes SHALL take effect at the next tick-counter wrap.

Reset
REQ-034 While rst_n=0, busy, done, mem_rd, mem_addr, pcm, audio, all pos/smp, and all counters SHALL be 0, and the FSM SHALL be in IDLE.
REQ-035 Reset asserted mid-frame SHALL abort all channels without done pulses; the first tick SHALL occur P cycles after rst_n rises.

Verification
REQ-036 Single channel (NCH=2, DW=8, rate_div=99, base0=0x100, len0=3, vol0=15, ROM[0x100..0x102]=16,32,48): start[0] -> mem_addr 0x100,0x101,0x102 on successive ticks; pcm=15,30,45; done[0] pulses once; busy[0]=0 afterwards.
REQ-037 Loop mode: same setup with loop0=1 -> addresses repeat 0x100,0x101,0x102,0x100...; no done pulse; stop[0] -> busy[0]=0 next cycle, pcm=0 after next MIX.
REQ-038 Saturation: both channels vol=15 with samples 255 and 200 -> pcm=255; vol0=8, sample 128, ch1 idle -> pcm=64.
REQ-039 Clamp: rate_div=0 with NCH=2 -> tick period = 6 cycles; with ch_len=0, start has no effect.
REQ-040 Conflicts: start[1] and stop[1] in the same cycle -> busy[1]=1, pos=0; start[0] issued in the MIX cycle -> pos[0]=0, not 1.
REQ-041 PWM and reset: pcm=64 -> audio high 64 of every 256 cycles; rst_n pulsed low mid-clip -> all outputs 0 immediately, no done pulse.
